aes_round_sched: RTL and testbench

Sequencing controller for the AES-128 encryption core. Accepts a new cipher key and starts round-key expansion in the round-key generator. Accepts plaintext blocks and steps the datapath through the initial AddRoundKey and rounds 1..NUM_ROUNDS. Presents the finished block through a valid/ready handshake. It owns `cur_round`, so the key generator and the round datapath stay aligned.

---
 rtl/aes_round_sched.sv | 190 +++++++++++++++++++
 tb/tb_aes_round_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// aes_round_sched: sequencing controller for an AES-128 encryption core.
//
// Takes a new cipher key and starts round-key expansion in the key generator.
// Takes plaintext blocks and steps the datapath through the initial
// AddRoundKey and rounds 1..NUM_ROUNDS. Presents the result through a
// valid/ready handshake. This block owns cur_round, so the key generator and
// the round datapath always see the same round index.
//
// Ports:
//   clk              system clock, all state on the rising edge
//   n_rst            asynchronous active-low reset
//   key_valid        new key present on the rx key bus
//   key_ready        controller accepts a key this cycle (IDLE only)
//   blk_valid        plaintext block present
//   blk_ready        controller accepts a block this cycle
//   chg_key          to key generator: load rx key and run expansion
//   change_key_done  from key generator: expansion complete
//   pre_add          enable the initial AddRoundKey with the original key
//   round_en         enable one cipher round in the datapath
//   last_round       final round, datapath bypasses MixColumns
//   cur_round[3:0]   round index to key generator and datapath
//   out_valid        ciphertext valid
//   out_ready        downstream accepts ciphertext
//   key_loaded       expanded key available for use
//   key_err          sticky: key expansion timed out
//   busy             controller not in IDLE
//
// NUM_ROUNDS must be at most 15 so the 4-bit round index never wraps.
// WAIT_LIMIT must be at most 255 so it fits the 8-bit wait counter.

module aes_round_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic       chg_key,
  input  logic       change_key_done,
  output logic       pre_add,
  output logic       round_en,
  output logic       last_round,
  output logic [3:0] cur_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       key_loaded,
  output logic       key_err,
  output logic       busy
);

  localparam logic [3:0] LP_LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] LP_WAIT_LIM   = 8'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXP,
    S_PRE_ADD,
    S_ROUND,
    S_OUTPUT
  } state_t;

  state_t     r_state;
  state_t     w_nxt_state;
  logic [3:0] r_cur_round;
  logic [3:0] w_nxt_round;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_nxt_wait;
  logic       r_key_loaded;
  logic       w_nxt_loaded;
  logic       r_key_err;
  logic       w_nxt_err;

  // Moore outputs, registered from the next state so they change cleanly
  // on the same edge as the state register.
  logic       r_chg_key;
  logic       r_pre_add;
  logic       r_round_en;
  logic       r_last_round;
  logic       r_out_valid;
  logic       r_busy;

  logic       w_idle;

  assign w_idle = (r_state == S_IDLE);

  // A coincident key wins over a block, so blk_ready is withheld while
  // key_valid is high; otherwise the block source would believe its block
  // was taken when the controller actually went off to expand the key.
  assign key_ready = w_idle;
  assign blk_ready = w_idle && r_key_loaded && !key_valid;

  assign chg_key    = r_chg_key;
  assign pre_add    = r_pre_add;
  assign round_en   = r_round_en;
  assign last_round = r_last_round;
  assign cur_round  = r_cur_round;
  assign out_valid  = r_out_valid;
  assign key_loaded = r_key_loaded;
  assign key_err    = r_key_err;
  assign busy       = r_busy;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_round  = r_cur_round;
    w_nxt_wait   = r_wait_cnt;
    w_nxt_loaded = r_key_loaded;
    w_nxt_err    = r_key_err;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          // A fresh key invalidates the old expansion and any prior error.
          w_nxt_state  = S_KEY_EXP;
          w_nxt_loaded = 1'b0;
          w_nxt_err    = 1'b0;
          w_nxt_wait   = 8'd0;
        end else if (blk_valid && r_key_loaded) begin
          w_nxt_state = S_PRE_ADD;
          w_nxt_round = 4'd0;
        end
      end
      S_KEY_EXP: begin
        // done is checked first so a completion on the timeout cycle counts.
        if (change_key_done) begin
          w_nxt_state  = S_IDLE;
          w_nxt_loaded = 1'b1;
        end else if (r_wait_cnt == LP_WAIT_LIM) begin
          w_nxt_state  = S_IDLE;
          w_nxt_err    = 1'b1;
          w_nxt_loaded = 1'b0;
        end else begin
          w_nxt_wait = r_wait_cnt + 8'd1;
        end
      end
      S_PRE_ADD: begin
        w_nxt_state = S_ROUND;
        w_nxt_round = 4'd1;
      end
      S_ROUND: begin
        // The index stops at the last round and is held through OUTPUT.
        if (r_cur_round == LP_LAST_ROUND) begin
          w_nxt_state = S_OUTPUT;
        end else begin
          w_nxt_round = r_cur_round + 4'd1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          w_nxt_state = S_IDLE;
          w_nxt_round = 4'd0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_round = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_cur_round  <= 4'd0;
      r_wait_cnt   <= 8'd0;
      r_key_loaded <= 1'b0;
      r_key_err    <= 1'b0;
      r_chg_key    <= 1'b0;
      r_pre_add    <= 1'b0;
      r_round_en   <= 1'b0;
      r_last_round <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cur_round  <= w_nxt_round;
      r_wait_cnt   <= w_nxt_wait;
      r_key_loaded <= w_nxt_loaded;
      r_key_err    <= w_nxt_err;
      r_chg_key    <= (w_nxt_state == S_KEY_EXP);
      r_pre_add    <= (w_nxt_state == S_PRE_ADD);
      r_round_en   <= (w_nxt_state == S_ROUND);
      r_last_round <= (w_nxt_state == S_ROUND) && (w_nxt_round == LP_LAST_ROUND);
      r_out_valid  <= (w_nxt_state == S_OUTPUT);
      r_busy       <= (w_nxt_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Testbench for aes_round_sched: each scenario task drives stimulus and
// compares the DUT against timelines derived from the controller's
// documented cycle behaviour (key accept, expansion, round sequence, output
// handshake, reset).

module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int WL = 255;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       key_valid;
  logic       key_ready;
  logic       blk_valid;
  logic       blk_ready;
  logic       chg_key;
  logic       change_key_done;
  logic       pre_add;
  logic       round_en;
  logic       last_round;
  logic [3:0] cur_round;
  logic       out_valid;
  logic       out_ready;
  logic       key_loaded;
  logic       key_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit m_loaded = 1'b0;

  always #5 clk = ~clk;

  aes_round_sched #(.NUM_ROUNDS(NR), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .n_rst(n_rst),
    .key_valid(key_valid), .key_ready(key_ready),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .chg_key(chg_key), .change_key_done(change_key_done),
    .pre_add(pre_add), .round_en(round_en), .last_round(last_round),
    .cur_round(cur_round), .out_valid(out_valid), .out_ready(out_ready),
    .key_loaded(key_loaded), .key_err(key_err), .busy(busy)
  );

  // Observation vectors, packed only for compact comparisons.
  function automatic logic [13:0] rst_obs();
    return {key_ready, blk_ready, chg_key, pre_add, round_en, last_round,
            out_valid, busy, key_loaded, key_err, cur_round};
  endfunction

  function automatic logic [10:0] blk_obs();
    return {pre_add, round_en, last_round, out_valid, key_ready, blk_ready,
            busy, cur_round};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; key_valid = 1'b0; blk_valid = 1'b0;
    change_key_done = 1'b0; out_ready = 1'b0;
    #7;
    checks++;
    if (rst_obs() !== {1'b1, 13'b0})
      $display("FAIL reset_in got=%b exp=%b", rst_obs(), {1'b1, 13'b0});
    if (rst_obs() !== {1'b1, 13'b0}) failures++;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++;
    if (rst_obs() !== {1'b1, 13'b0}) begin
      failures++;
      $display("FAIL reset_after got=%b exp=%b", rst_obs(), {1'b1, 13'b0});
    end
    m_loaded = 1'b0;
  endtask

  // lat = chg_key cycle on which done is raised (0 = never raised).
  task automatic test_key_load(input int lat, input bit with_blk);
    int n;
    int exp_n;
    bit exp_ok;
    exp_ok = (lat >= 1 && lat <= WL + 1);
    exp_n  = exp_ok ? lat : WL + 1;
    key_valid = 1'b1;
    blk_valid = with_blk;
    #1;
    checks++;
    if ({key_ready, blk_ready} !== 2'b10) begin
      failures++;
      $display("FAIL key_accept_ready got=%b exp=10", {key_ready, blk_ready});
    end
    tick();
    key_valid = 1'b0;
    blk_valid = 1'b0;
    n = 0;
    while (chg_key === 1'b1 && n < WL + 20) begin
      n++;
      change_key_done = (n == lat);
      tick();
    end
    change_key_done = 1'b0;
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL chg_key_len got=%0d exp=%0d", n, exp_n);
    end
    checks++;
    if ({key_loaded, key_err, key_ready, busy, pre_add} !==
        {exp_ok, !exp_ok, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL key_result got=%b exp=%b",
               {key_loaded, key_err, key_ready, busy, pre_add},
               {exp_ok, !exp_ok, 1'b1, 1'b0, 1'b0});
    end
    m_loaded = exp_ok;
    if (!exp_ok) begin
      blk_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if ({blk_ready, busy, pre_add} !== 3'b000) begin
          failures++;
          $display("FAIL blk_ignored_no_key got=%b exp=000",
                   {blk_ready, busy, pre_add});
        end
        tick();
      end
      blk_valid = 1'b0;
    end
  endtask

  task automatic test_block(input int stall, input bit key_noise);
    logic [10:0] exp;
    out_ready = 1'b0;
    blk_valid = 1'b1;
    #1;
    checks++;
    if (blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL blk_ready_idle got=%b exp=1", blk_ready);
    end
    tick();
    blk_valid = 1'b0;
    key_valid = key_noise;
    for (int k = 1; k <= NR + 1; k++) begin
      exp = {1'(k == 1), 1'(k >= 2), 1'(k == NR + 1), 4'b0001,
             4'((k == 1) ? 0 : k - 1)};
      checks++;
      if (blk_obs() !== exp) begin
        failures++;
        $display("FAIL round_seq k=%0d got=%b exp=%b", k, blk_obs(), exp);
      end
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      out_ready = (s == stall);
      exp = {7'b0001001, 4'(NR)};
      checks++;
      if (blk_obs() !== exp) begin
        failures++;
        $display("FAIL output_hold s=%0d got=%b exp=%b", s, blk_obs(), exp);
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, cur_round, key_ready, blk_ready} !==
        {1'b0, 1'b0, 4'd0, 1'b1, !key_noise}) begin
      failures++;
      $display("FAIL after_handshake got=%b exp=%b",
               {out_valid, busy, cur_round, key_ready, blk_ready},
               {1'b0, 1'b0, 4'd0, 1'b1, !key_noise});
    end
    if (key_noise) begin
      // The key held during the block is taken only now.
      tick();
      key_valid = 1'b0;
      checks++;
      if ({chg_key, key_loaded} !== 2'b10) begin
        failures++;
        $display("FAIL deferred_key got=%b exp=10", {chg_key, key_loaded});
      end
      change_key_done = 1'b1;
      tick();
      change_key_done = 1'b0;
      checks++;
      if ({key_loaded, busy} !== 2'b10) begin
        failures++;
        $display("FAIL deferred_key_done got=%b exp=10", {key_loaded, busy});
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    int nblk;
    int n;
    prev = -1;
    nblk = 0;
    blk_valid = 1'b1;
    out_ready = 1'b1;
    for (int t = 1; t < 200 && nblk < 3; t++) begin
      tick();
      if (pre_add === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (t - prev != NR + 3) begin
            failures++;
            $display("FAIL b2b_interval got=%0d exp=%0d", t - prev, NR + 3);
          end
        end
        prev = t;
        nblk++;
      end
    end
    blk_valid = 1'b0;
    checks++;
    if (nblk != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", nblk);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain_timeout got=%b exp=0", busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    n = 0;
    while (!(round_en === 1'b1 && cur_round === 4'd5) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL reach_round5 got=%0d exp=5", cur_round);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (rst_obs() !== {1'b1, 13'b0}) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", rst_obs(), {1'b1, 13'b0});
    end
    @(negedge clk);
    n_rst = 1'b1;
    m_loaded = 1'b0;
    tick();
    blk_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({blk_ready, busy, pre_add, key_loaded} !== 4'b0000) begin
        failures++;
        $display("FAIL blk_after_reset got=%b exp=0000",
                 {blk_ready, busy, pre_add, key_loaded});
      end
      tick();
    end
    blk_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key_load(12, 1'b0);
    test_block(0, 1'b0);
    test_block(5, 1'b0);
    for (int i = 0; i < 4; i++) test_block(int'($urandom_range(0, 6)), 1'b0);
    test_back_to_back();
    test_key_load(0, 1'b0);
    test_key_load(int'($urandom_range(1, 40)), 1'b0);
    test_key_load(WL + 1, 1'b0);
    test_block(int'($urandom_range(0, 3)), 1'b0);
    test_key_load(int'($urandom_range(1, 20)), 1'b1);
    test_block(int'($urandom_range(0, 4)), 1'b1);
    test_block(0, 1'b0);
    test_reset_mid();
    test_key_load(int'($urandom_range(1, 30)), 1'b0);
    test_block(int'($urandom_range(0, 6)), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
